// File: rtl/spdif_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : spdif_pkg
// Purpose  : Shared constants and arbiter state encoding for the S/PDIF
//            source arbiter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package spdif_pkg;

  localparam int SAMPLE_W       = 32;
  localparam int UNDERRUN_CNT_W = 16;

  localparam logic [SAMPLE_W-1:0] SPDIF_SILENCE = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/spdif_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : spdif_rr_arbiter
// Purpose  : Combinational round-robin pick: first requester at or after the
//            pointer (wrapping), as a one-hot grant plus a valid flag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module spdif_rr_arbiter
  import spdif_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int PTR_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_SRC-1:0] o_grant,
  output logic               o_valid
);

  logic w_found;

  always_comb begin
    w_found = 1'b0;
    o_grant = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (!w_found && i_req[(int'(i_ptr) + j) % NUM_SRC]) begin
        w_found                                   = 1'b1;
        o_grant[(int'(i_ptr) + j) % NUM_SRC]      = 1'b1;
      end
    end
    o_valid = w_found;
  end

endmodule
`default_nettype wire

// File: rtl/spdif_src_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : spdif_src_arbiter
// Purpose  : Round-robin sharing of one S/PDIF transmitter between NUM_SRC
//            sources through a one-entry prefetch register; silence on empty.
//            Define SPDIF_ARB_STATS_EN to build the saturating underrun count.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module spdif_src_arbiter
  import spdif_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int IDLE_TIMEOUT = 64,
  parameter int SAMPLE_W     = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_SRC-1:0]          src_req_i,
  input  logic [NUM_SRC-1:0]          src_tvalid_i,
  input  logic [NUM_SRC*SAMPLE_W-1:0] src_tdata_i,
  output logic [NUM_SRC-1:0]          src_tready_o,
  output logic [NUM_SRC-1:0]          grant_o,
  input  logic                        sample_req_i,
  output logic [SAMPLE_W-1:0]         sample_o,
  output logic                        timeout_o,
  output logic [UNDERRUN_CNT_W-1:0]   underrun_cnt_o
);

  localparam int PTR_W = $clog2(NUM_SRC);
  localparam logic [UNDERRUN_CNT_W-1:0] c_idle_timeout = UNDERRUN_CNT_W'(IDLE_TIMEOUT);
  localparam logic [UNDERRUN_CNT_W-1:0] c_cnt_max      = '1;

  arb_state_e                r_state;
  arb_state_e                w_state_nxt;
  logic [PTR_W-1:0]          r_rr_ptr;
  logic [NUM_SRC-1:0]        r_grant;
  logic [SAMPLE_W-1:0]       r_buf;
  logic                      r_buf_valid;
  logic                      r_timeout;
  logic [UNDERRUN_CNT_W-1:0] r_consec;

  logic [NUM_SRC-1:0]        w_rr_grant;
  logic                      w_rr_valid;
  logic [PTR_W-1:0]          w_rr_idx;
  logic [SAMPLE_W-1:0]       w_owner_data;
  logic                      w_owner_req;
  logic                      w_load;
  logic                      w_underrun;
  logic                      w_timeout_hit;
  logic                      w_grant_new;
  logic                      w_release;
  logic                      w_timeout_exit;

  spdif_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_rr (
    .i_req   (src_req_i),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_rr_grant),
    .o_valid (w_rr_valid)
  );

  always_comb begin
    w_rr_idx     = '0;
    w_owner_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (w_rr_grant[k]) w_rr_idx = PTR_W'(k);
      if (r_grant[k])    w_owner_data = src_tdata_i[k*SAMPLE_W +: SAMPLE_W];
    end
  end

  assign src_tready_o  = (r_state == ST_OWN && !r_buf_valid) ? r_grant : '0;
  assign w_owner_req   = |(src_req_i & r_grant);
  assign w_load        = |(src_tready_o & src_tvalid_i);
  assign w_underrun    = sample_req_i && !r_buf_valid && (r_state != ST_IDLE);
  assign w_timeout_hit = (r_consec >= c_idle_timeout);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_new    = 1'b0;
    w_release      = 1'b0;
    w_timeout_exit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rr_valid) begin
          w_state_nxt = ST_OWN;
          w_grant_new = 1'b1;
        end
      end
      ST_OWN: begin
        if (w_timeout_hit) begin
          w_state_nxt    = ST_DRAIN;
          w_timeout_exit = 1'b1;
        end else if (!w_owner_req) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Handover only on a sample boundary, even with an empty buffer.
        if (sample_req_i) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_buf       <= '0;
      r_buf_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_consec    <= '0;
    end else begin
      r_timeout <= w_timeout_exit;

      if (w_grant_new) begin
        r_grant  <= w_rr_grant;
        r_rr_ptr <= (w_rr_idx == PTR_W'(NUM_SRC - 1)) ? '0 : w_rr_idx + PTR_W'(1);
      end else if (w_release) begin
        r_grant <= '0;
      end

      // A load only happens into an empty buffer, so it outranks consumption.
      if (w_load) begin
        r_buf       <= w_owner_data;
        r_buf_valid <= 1'b1;
      end else if (sample_req_i) begin
        r_buf       <= SAMPLE_W'(SPDIF_SILENCE);
        r_buf_valid <= 1'b0;
      end

      // A fresh owner starts with a clean underrun history.
      if (w_grant_new) begin
        r_consec <= '0;
      end else if (w_underrun) begin
        if (r_consec != c_cnt_max) r_consec <= r_consec + UNDERRUN_CNT_W'(1);
      end else if (sample_req_i && r_buf_valid) begin
        r_consec <= '0;
      end
    end
  end

`ifdef SPDIF_ARB_STATS_EN
  logic [UNDERRUN_CNT_W-1:0] r_underrun_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_underrun_cnt <= '0;
    end else if (w_underrun && r_underrun_cnt != c_cnt_max) begin
      r_underrun_cnt <= r_underrun_cnt + UNDERRUN_CNT_W'(1);
    end
  end

  assign underrun_cnt_o = r_underrun_cnt;
`else
  assign underrun_cnt_o = '0;
`endif

  assign grant_o   = r_grant;
  assign sample_o  = r_buf;
  assign timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_spdif_src_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_spdif_src_arbiter
// Purpose  : Self-checking bench for spdif_src_arbiter (4 sources, timeout 4).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_spdif_src_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 4;
`ifdef SPDIF_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i;
  logic [N-1:0]  src_req_i;
  logic [N-1:0]  src_tvalid_i;
  logic [N*32-1:0] src_tdata_i;
  logic [N-1:0]  src_tready_o;
  logic [N-1:0]  grant_o;
  logic          sample_req_i;
  logic [31:0]   sample_o;
  logic          timeout_o;
  logic [15:0]   underrun_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spdif_src_arbiter #(
    .NUM_SRC      (N),
    .IDLE_TIMEOUT (TIMEOUT),
    .SAMPLE_W     (32)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .src_req_i      (src_req_i),
    .src_tvalid_i   (src_tvalid_i),
    .src_tdata_i    (src_tdata_i),
    .src_tready_o   (src_tready_o),
    .grant_o        (grant_o),
    .sample_req_i   (sample_req_i),
    .sample_o       (sample_o),
    .timeout_o      (timeout_o),
    .underrun_cnt_o (underrun_cnt_o)
  );

  // Reference model: owner index (-1 = none), drain flag, prefetch queue.
  int          m_owner;
  bit          m_drain;
  logic [31:0] m_q[$];
  int          m_rr;
  int          m_consec;
  int          m_under;
  bit          m_to;

  function automatic void model_reset();
    m_owner = -1; m_drain = 1'b0; m_q.delete();
    m_rr = 0; m_consec = 0; m_under = 0; m_to = 1'b0;
  endfunction

  function automatic void model_tick();
    bit had;
    int consec0, own0;
    bit drain0;
    had = (m_q.size() != 0); consec0 = m_consec; own0 = m_owner; drain0 = m_drain;
    m_to = 1'b0;
    if (sample_req_i) begin
      if (had) begin
        void'(m_q.pop_front());
        m_consec = 0;
      end else if (own0 >= 0) begin
        m_under++;
        if (m_consec < 65535) m_consec++;
      end
    end
    if (own0 >= 0 && !drain0 && !had && src_tvalid_i[own0])
      m_q.push_back(src_tdata_i[own0*32 +: 32]);
    if (own0 < 0) begin
      for (int i = 0; i < N; i++) begin
        if (src_req_i[(m_rr + i) % N]) begin
          m_owner  = (m_rr + i) % N;
          m_rr     = (m_owner + 1) % N;
          m_consec = 0;
          break;
        end
      end
    end else if (!drain0) begin
      if (consec0 >= TIMEOUT) begin
        m_drain = 1'b1; m_to = 1'b1;
      end else if (!src_req_i[own0]) begin
        m_drain = 1'b1;
      end
    end else if (sample_req_i) begin
      m_owner = -1; m_drain = 1'b0;
    end
  endfunction

  function automatic logic [N-1:0] exp_grant();
    return (m_owner >= 0) ? N'(1 << m_owner) : '0;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    return (m_owner >= 0 && !m_drain && m_q.size() == 0) ? exp_grant() : '0;
  endfunction

  function automatic logic [31:0] exp_sample();
    return (m_q.size() != 0) ? m_q[0] : 32'h0;
  endfunction

  function automatic logic [15:0] exp_cnt(input int n);
    return STATS ? 16'((n > 65535) ? 65535 : n) : 16'h0;
  endfunction

  task automatic tick();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; src_req_i = '0; src_tvalid_i = '0; src_tdata_i = '0; sample_req_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant_o !== 4'b0) begin errors++; $display("FAIL reset_grant got %b want 0000", grant_o); end
    checks++; if (src_tready_o !== 4'b0) begin errors++; $display("FAIL reset_ready got %b want 0000", src_tready_o); end
    checks++; if (sample_o !== 32'h0) begin errors++; $display("FAIL reset_sample got %h want 0", sample_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout_o); end
    checks++; if (underrun_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_cnt got %0d want 0", underrun_cnt_o); end
  endtask

  task automatic test_single_source();
    do_reset();
    src_req_i = 4'b0001; src_tvalid_i = 4'b0001;
    src_tdata_i = {32'h0, 32'h0, 32'h0, 32'h1234_5678};
    for (int i = 0; i < 100; i++) begin
      sample_req_i = (i % 20 == 19);
      if (i >= 2) begin
        checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL single_grant cyc %0d got %b want 0001", i, grant_o); end
      end
      if (sample_req_i) begin
        checks++; if (sample_o !== 32'h1234_5678) begin errors++; $display("FAIL single_capture cyc %0d got %h want 12345678", i, sample_o); end
      end
      tick();
    end
    sample_req_i = 1'b0;
    checks++; if (underrun_cnt_o !== 16'h0) begin errors++; $display("FAIL single_underrun got %0d want 0", underrun_cnt_o); end
  endtask

  task automatic test_two_sources();
    logic [31:0] d1, d3;
    logic [N-1:0] order[$];
    logic [N-1:0] last_g, last_rdy;
    int cnt1, cnt3, cyc;
    do_reset();
    d1 = 32'h1111_0001; d3 = 32'h3333_0003;
    cnt1 = 0; cnt3 = 0; cyc = 0; last_g = '0; last_rdy = '0;
    src_req_i = 4'b1010; src_tvalid_i = 4'b1010;
    src_tdata_i = {d3, 32'h0, d1, 32'h0};
    while (order.size() < 3 && cyc < 3000) begin
      sample_req_i = (cyc % 8 == 7);
      checks++; if (grant_o !== exp_grant()) begin errors++; $display("FAIL two_grant cyc %0d got %b want %b", cyc, grant_o, exp_grant()); end
      checks++; if (sample_o !== exp_sample()) begin errors++; $display("FAIL two_sample cyc %0d got %h want %h", cyc, sample_o, exp_sample()); end
      checks++; if ($countones(src_tready_o) > 1) begin errors++; $display("FAIL two_ready_onehot cyc %0d got %b want <=1 bit", cyc, src_tready_o); end
      checks++; if (src_tready_o != 0 && last_rdy != 0 && src_tready_o != last_rdy) begin
        errors++; $display("FAIL two_ready_gap cyc %0d got %b after %b want idle cycle", cyc, src_tready_o, last_rdy);
      end
      if (grant_o != 0 && grant_o != last_g) order.push_back(grant_o);
      last_g = grant_o; last_rdy = src_tready_o;
      if (sample_req_i && sample_o == d1) cnt1++;
      if (sample_req_i && sample_o == d3) cnt3++;
      if (cnt1 >= 2) src_req_i[1] = 1'b0;
      if (cnt3 >= 2) src_req_i[3] = 1'b0;
      if (cnt1 >= 2 && !grant_o[1]) begin src_req_i[1] = 1'b1; cnt1 = 0; end
      if (cnt3 >= 2 && !grant_o[3]) begin src_req_i[3] = 1'b1; cnt3 = 0; end
      tick();
      cyc++;
    end
    sample_req_i = 1'b0;
    checks++;
    if (order.size() != 3) begin
      errors++; $display("FAIL two_order_len got %0d grants want 3", order.size());
    end else begin
      checks++; if (order[0] !== 4'b0010) begin errors++; $display("FAIL two_order0 got %b want 0010", order[0]); end
      checks++; if (order[1] !== 4'b1000) begin errors++; $display("FAIL two_order1 got %b want 1000", order[1]); end
      checks++; if (order[2] !== 4'b0010) begin errors++; $display("FAIL two_order2 got %b want 0010", order[2]); end
    end
  endtask

  task automatic test_timeout();
    int silent, pulses, cyc;
    bit seen;
    do_reset();
    silent = 0; pulses = 0; cyc = 0; seen = 1'b0;
    src_req_i = 4'b0001; src_tvalid_i = 4'b0000;
    src_tdata_i = {$urandom, $urandom, $urandom, $urandom};
    while (!seen && cyc < 200) begin
      sample_req_i = (cyc % 5 == 4);
      if (timeout_o) begin
        seen = 1'b1; pulses++;
        checks++; if (underrun_cnt_o !== exp_cnt(4)) begin errors++; $display("FAIL to_cnt got %0d want %0d", underrun_cnt_o, exp_cnt(4)); end
        checks++; if (silent != 4) begin errors++; $display("FAIL to_silent got %0d want 4", silent); end
        src_req_i = 4'b0000;
      end else if (sample_req_i && grant_o != 0) begin
        checks++; if (sample_o !== 32'h0) begin errors++; $display("FAIL to_capture got %h want 0", sample_o); end
        silent++;
      end
      tick();
      cyc++;
    end
    checks++; if (!seen) begin errors++; $display("FAIL to_pulse got none want pulse within 200 cycles"); end
    for (int i = 0; i < 40; i++) begin
      sample_req_i = (cyc % 5 == 4);
      if (timeout_o) pulses++;
      tick();
      cyc++;
    end
    sample_req_i = 1'b0;
    checks++; if (pulses != 1) begin errors++; $display("FAIL to_pulses got %0d want 1", pulses); end
    checks++; if (grant_o !== 4'b0) begin errors++; $display("FAIL to_grant got %b want 0000", grant_o); end
    checks++; if (underrun_cnt_o !== exp_cnt(5)) begin errors++; $display("FAIL to_cnt_end got %0d want %0d", underrun_cnt_o, exp_cnt(5)); end
  endtask

  task automatic test_coincident();
    int cyc;
    do_reset();
    src_req_i = 4'b0001; src_tvalid_i = 4'b0000; cyc = 0;
    while (grant_o !== 4'b0001 && cyc < 10) begin tick(); cyc++; end
    checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL co_grant got %b want 0001", grant_o); end
    src_tvalid_i = 4'b0001; src_tdata_i[31:0] = 32'hAAAA_5555; sample_req_i = 1'b1;
    checks++; if (src_tready_o !== 4'b0001) begin errors++; $display("FAIL co_ready got %b want 0001", src_tready_o); end
    checks++; if (sample_o !== 32'h0) begin errors++; $display("FAIL co_capture0 got %h want 0", sample_o); end
    tick();
    src_tvalid_i = 4'b0000; sample_req_i = 1'b0;
    checks++; if (underrun_cnt_o !== exp_cnt(1)) begin errors++; $display("FAIL co_cnt got %0d want %0d", underrun_cnt_o, exp_cnt(1)); end
    checks++; if (sample_o !== 32'hAAAA_5555) begin errors++; $display("FAIL co_capture1 got %h want aaaa5555", sample_o); end
    sample_req_i = 1'b1;
    tick();
    sample_req_i = 1'b0;
    checks++; if (sample_o !== 32'h0) begin errors++; $display("FAIL co_cleared got %h want 0", sample_o); end
    src_req_i = 4'b0000;
  endtask

  task automatic test_async_reset();
    logic [31:0] d2;
    do_reset();
    d2 = $urandom;
    src_req_i = 4'b0100; src_tvalid_i = 4'b0100;
    src_tdata_i = {32'h0, d2, 32'h0, 32'h0};
    repeat (4) tick();
    checks++; if (sample_o !== d2 || grant_o !== 4'b0100) begin
      errors++; $display("FAIL ar_pre got %b/%h want 0100/%h", grant_o, sample_o, d2);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++; if (grant_o !== 4'b0) begin errors++; $display("FAIL ar_grant got %b want 0000", grant_o); end
    checks++; if (sample_o !== 32'h0) begin errors++; $display("FAIL ar_sample got %h want 0", sample_o); end
    checks++; if (src_tready_o !== 4'b0) begin errors++; $display("FAIL ar_ready got %b want 0000", src_tready_o); end
    checks++; if (timeout_o !== 1'b0 || underrun_cnt_o !== 16'h0) begin
      errors++; $display("FAIL ar_misc got %b/%0d want 0/0", timeout_o, underrun_cnt_o);
    end
    model_reset();
    src_req_i = 4'b1111;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    tick();
    checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL ar_restart got %b want 0001", grant_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(15) == 0) src_req_i[$urandom_range(N-1)] ^= 1'b1;
      src_tvalid_i = N'($urandom);
      src_tdata_i  = {$urandom, $urandom, $urandom, $urandom};
      sample_req_i = ($urandom_range(5) == 0);
      checks++; if (grant_o !== exp_grant()) begin errors++; $display("FAIL rnd_grant cyc %0d got %b want %b", cyc, grant_o, exp_grant()); end
      checks++; if (src_tready_o !== exp_ready()) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, src_tready_o, exp_ready()); end
      checks++; if (sample_o !== exp_sample()) begin errors++; $display("FAIL rnd_sample cyc %0d got %h want %h", cyc, sample_o, exp_sample()); end
      checks++; if (timeout_o !== m_to) begin errors++; $display("FAIL rnd_timeout cyc %0d got %b want %b", cyc, timeout_o, m_to); end
      checks++; if (underrun_cnt_o !== exp_cnt(m_under)) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", cyc, underrun_cnt_o, exp_cnt(m_under)); end
      tick();
    end
    sample_req_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_two_sources();
    test_timeout();
    test_coincident();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spdif_src_arbiter.md
Name: spdif_src_arbiter

Overview:
- Shares the single S/PDIF transmitter core between NUM_SRC audio sources.
- Exactly one source owns the transmitter at a time. Ownership changes only at sample boundaries, using round-robin among requesting sources.
- A one-entry prefetch register feeds the core's sample request strobe. When the prefetch register is empty, silence is inserted.
- Sits between the audio source streams and the transmitter core's sample_i / sample_req_o pair.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- IDLE_TIMEOUT, 64, consecutive underruns after which ownership is forcibly released (1..65535).
- SAMPLE_W, 32, sample word width: {right[15:0], left[15:0]}.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- src_req_i  in  NUM_SRC  per-source ownership request (level).
- src_tvalid_i  in  NUM_SRC  per-source sample valid.
- src_tdata_i  in  NUM_SRC*SAMPLE_W  packed samples; source k occupies bits [k*SAMPLE_W +: SAMPLE_W].
- src_tready_o  out  NUM_SRC  per-source ready.
- grant_o  out  NUM_SRC  one-hot current owner; all zero when no owner.
- sample_req_i  in  1  one-cycle pulse from the transmitter; the sample is consumed that cycle.
- sample_o  out  SAMPLE_W  to transmitter sample_i, registered.
- timeout_o  out  1  one-cycle pulse on forced release.
- underrun_cnt_o  out  16  saturating underrun count.

Behaviour:
- Reset (asynchronous):
  - State = IDLE; rr pointer = 0.
  - grant_o = 0, src_tready_o = 0, sample_o = 0, timeout_o = 0, underrun_cnt_o = 0.
  - buf_valid = 0; consecutive-underrun counter = 0.
- FSM states: IDLE, OWN, DRAIN.
- IDLE:
  - If any src_req_i is set, grant the first requester at or after rr pointer (wrapping).
  - grant_o is registered and asserts the next cycle; state becomes OWN.
  - rr pointer is set to winner+1 mod NUM_SRC.
- OWN:
  - src_tready_o[owner] = !buf_valid; all other ready bits are 0.
  - On tvalid&tready: buf (sample_o) is loaded and buf_valid = 1 next cycle.
  - Leave OWN for DRAIN when src_req_i[owner] deasserts, or when the consecutive-underrun counter reaches IDLE_TIMEOUT.
  - A timeout exit pulses timeout_o for one cycle.
- DRAIN:
  - tready = 0; grant_o holds.
  - Waits for the next sample_req_i, which consumes any buffered sample. The cycle after that request, grant_o = 0 and state = IDLE.
  - If buf is empty on entry, DRAIN still waits for one sample_req_i. This keeps switch timing aligned to sample boundaries.
- Sample consumption, on a sample_req_i cycle in any state:
  - The core captures the current sample_o.
  - sample_o clears to 0 next cycle; buf_valid clears.
- Underrun:
  - An underrun is sample_req_i while !buf_valid in OWN or DRAIN. The core receives 0 (silence).
  - underrun_cnt_o increments, saturating at 0xFFFF.
  - The consecutive-underrun counter increments; any successful sample consumption resets it to 0.
  - sample_req_i in IDLE is silence but is not counted as an underrun.
- Simultaneous events:
  - sample_req_i in the same cycle as a load (buf empty, tvalid&tready): counted as an underrun. The load wins and buf_valid = 1 next cycle.
  - src_req_i deasserting in the same cycle as a handshake: the handshake completes, then DRAIN.
- Ownership switch: no source sees tready for at least one cycle between owners. A new owner's first sample is never output before the old owner's buffered sample is consumed.
- Latency: grant +1 cycle after request in IDLE; sample visible on sample_o +1 cycle after handshake.

Optional Feature:
- Macro SPDIF_ARB_STATS_EN.
  - Defined: underrun_cnt_o behaves as above.
  - Undefined: underrun_cnt_o is tied to 0 and its counter is not built. The consecutive-underrun counter and timeout still exist.

Decomposition:
- Package spdif_pkg:
  - SAMPLE_W.
  - SPDIF_SILENCE = 32'h0.
  - Arbiter state enum (IDLE/OWN/DRAIN).
  - UNDERRUN_CNT_W = 16.
- Sub-module spdif_rr_arbiter: combinational round-robin pick from a request vector and pointer, returning a one-hot winner plus a valid flag.

Test Plan:
- Single source 0 requesting, tdata 0x1234_5678, sample_req_i every 20 cycles:
  - grant_o = 4'b0001.
  - Core captures 0x12345678 on each request.
  - underrun_cnt_o stays 0.
- Sources 1 and 3 both requesting from reset, each releasing after 2 samples:
  - Grant order is 1, then 3, then 1.
  - Each handover waits for one sample_req_i in DRAIN.
  - Ready bits are never simultaneously high.
- Owner holds src_tvalid_i low, IDLE_TIMEOUT = 4:
  - 4 silent captures of 0x0.
  - timeout_o pulses once.
  - underrun_cnt_o = 4.
  - grant_o returns to 0.
- sample_req_i coincident with the first handshake (tdata 0xAAAA_5555):
  - Captured value is 0.
  - underrun_cnt_o = 1.
  - The next request captures 0xAAAA5555.
- rst_i asserted mid-OWN with buf_valid = 1:
  - All outputs are 0 immediately (asynchronous).
  - Arbitration restarts from source 0 after release.
- Compile without SPDIF_ARB_STATS_EN and repeat the timeout test: underrun_cnt_o = 0 and timeout behaviour is unchanged.
